bus_timer_periph: RTL and testbench

Memory-mapped timer/counter peripheral that acts as the responder on the CPU data bus (`busWe`, `busAddr`, `busWData`, `Byte_Enable` in; `busRData` out). It holds a prescaler, an auto-reload counter and an update-interrupt flag, and raises `irq` when the counter wraps. It sits behind the system address decoder, which asserts `busSel` for this block's address window.

---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_prescaler.sv | 38 +++
 rtl/bus_timer_periph.sv | 131 +++++++++++++
 tb/tb_bus_timer_periph.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the bus timer peripheral: register offsets,
// CTRL bit positions, the CTRL register layout and byte-lane merge helper.
package timer_pkg;

  localparam logic [2:0] CTRL_OFS   = 3'd0;
  localparam logic [2:0] PSC_OFS    = 3'd1;
  localparam logic [2:0] ARR_OFS    = 3'd2;
  localparam logic [2:0] CNT_OFS    = 3'd3;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;
  localparam int CTRL_IE_BIT  = 2;
  localparam int CTRL_OS_BIT  = 3;

  typedef struct packed {
    logic oneshot;
    logic ie;
    logic clr;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: free-running divider that emits a one-cycle tick whenever
// its count has reached (or passed) the programmed reload value.
module timer_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] psc,
  output logic             tick
);

  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  // >= rather than == so that lowering PSC below pcnt still ticks next cycle
  assign tick = en & (pcnt_q >= psc);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/bus_timer_periph.sv
// Memory-mapped timer: register file, auto-reload counter, update flag,
// zero-wait-state read mux and level interrupt.
module bus_timer_periph
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busSel,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [3:0]  Byte_Enable,
  output logic [31:0] busRData,
  output logic        irq
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] arr_q, arr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uif_q, uif_d;

  logic [2:0]  ofs;
  logic        wr_en, ctrl_wr, clr, w1c, tick, reload;
  logic [31:0] psc_ext, arr_ext, cnt_ext;
  logic [31:0] psc_wr, arr_wr, cnt_wr;
  logic [31:0] rdata;
  logic        unused_addr;

  assign ofs         = busAddr[4:2];
  assign unused_addr = ^{busAddr[31:5], busAddr[1:0]};

  assign wr_en   = busSel & busWe;
  assign ctrl_wr = wr_en & (ofs == CTRL_OFS) & Byte_Enable[0];
  assign clr     = ctrl_wr & busWData[CTRL_CLR_BIT];
  assign w1c     = wr_en & (ofs == STATUS_OFS) & Byte_Enable[0] & busWData[0];
  // CLR suppresses the tick entirely, so no reload/UIF on a clearing edge
  assign reload  = tick & ~clr & (cnt_q >= arr_q);

  timer_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q.en),
    .clr   (clr),
    .psc   (psc_q),
    .tick  (tick)
  );

  always_comb begin
    psc_ext = '0;
    arr_ext = '0;
    cnt_ext = '0;
    psc_ext[CNT_W-1:0] = psc_q;
    arr_ext[CNT_W-1:0] = arr_q;
    cnt_ext[CNT_W-1:0] = cnt_q;
  end

  assign psc_wr = be_merge(psc_ext, busWData, Byte_Enable);
  assign arr_wr = be_merge(arr_ext, busWData, Byte_Enable);
  assign cnt_wr = be_merge(cnt_ext, busWData, Byte_Enable);

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d.en      = busWData[CTRL_EN_BIT];
      ctrl_d.ie      = busWData[CTRL_IE_BIT];
      ctrl_d.oneshot = busWData[CTRL_OS_BIT];
    end else if (reload & ctrl_q.oneshot) begin
      ctrl_d.en = 1'b0;
    end
    ctrl_d.clr = 1'b0;

    psc_d = psc_q;
    if (wr_en && ofs == PSC_OFS) psc_d = psc_wr[CNT_W-1:0];

    arr_d = arr_q;
    if (wr_en && ofs == ARR_OFS) arr_d = arr_wr[CNT_W-1:0];

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en && ofs == CNT_OFS) begin
      cnt_d = cnt_wr[CNT_W-1:0];
    end else if (reload) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // hardware set takes priority over a same-cycle software clear
    uif_d = uif_q;
    if (w1c)    uif_d = 1'b0;
    if (reload) uif_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      psc_q  <= '0;
      arr_q  <= '0;
      cnt_q  <= '0;
      uif_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      psc_q  <= psc_d;
      arr_q  <= arr_d;
      cnt_q  <= cnt_d;
      uif_q  <= uif_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      CTRL_OFS:   rdata[3:0] = {ctrl_q.oneshot, ctrl_q.ie, 1'b0, ctrl_q.en};
      PSC_OFS:    rdata = psc_ext;
      ARR_OFS:    rdata = arr_ext;
      CNT_OFS:    rdata = cnt_ext;
      STATUS_OFS: rdata[0] = uif_q;
      default:    rdata = '0;
    endcase
  end

  assign busRData = busSel ? rdata : '0;
  assign irq      = uif_q & ctrl_q.ie;

endmodule

// File: tb/tb_bus_timer_periph.sv
// Bench for bus_timer_periph: directed scenarios with literal expectations
// plus randomized bus traffic checked every cycle against a behavioural model.
module tb_bus_timer_periph;

  localparam logic [2:0] O_CTRL = 3'd0, O_PSC = 3'd1, O_ARR = 3'd2,
                         O_CNT = 3'd3, O_STAT = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busSel = 1'b0;
  logic        busWe = 1'b0;
  logic [31:0] busAddr = '0;
  logic [31:0] busWData = '0;
  logic [3:0]  Byte_Enable = '0;
  logic [31:0] busRData;
  logic        irq;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  bus_timer_periph dut (
    .clk         (clk),
    .reset       (reset),
    .busSel      (busSel),
    .busWe       (busWe),
    .busAddr     (busAddr),
    .busWData    (busWData),
    .Byte_Enable (Byte_Enable),
    .busRData    (busRData),
    .irq         (irq)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_psc = '0, m_arr = '0, m_cnt = '0, m_pcnt = '0;
  bit          m_en = 0, m_ie = 0, m_os = 0, m_uif = 0;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] r;
    r = '0;
    if (busSel) begin
      case (busAddr[4:2])
        O_CTRL: r = {28'd0, m_os, m_ie, 1'b0, m_en};
        O_PSC:  r = m_psc;
        O_ARR:  r = m_arr;
        O_CNT:  r = m_cnt;
        O_STAT: r = {31'd0, m_uif};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit wr, clr, tick, wrap;
    logic [2:0] o;
    if (!reset) begin
      m_psc = 0; m_arr = 0; m_cnt = 0; m_pcnt = 0;
      m_en = 0; m_ie = 0; m_os = 0; m_uif = 0;
    end else begin
      wr   = busSel && busWe;
      o    = busAddr[4:2];
      clr  = wr && o == O_CTRL && Byte_Enable[0] && busWData[1];
      tick = m_en && (m_pcnt >= m_psc) && !clr;
      wrap = tick && (m_cnt >= m_arr);
      // prescaler
      if (clr || (m_en && m_pcnt >= m_psc)) m_pcnt = 0;
      else if (m_en) m_pcnt = m_pcnt + 1;
      // counter: bus write beats the tick, CLR beats everything
      if (clr) m_cnt = 0;
      else if (wr && o == O_CNT) m_cnt = lane_merge(m_cnt, busWData, Byte_Enable);
      else if (wrap) m_cnt = 0;
      else if (tick) m_cnt = m_cnt + 1;
      if (wrap) m_uif = 1;
      else if (wr && o == O_STAT && Byte_Enable[0] && busWData[0]) m_uif = 0;
      if (wr && o == O_CTRL && Byte_Enable[0]) begin
        m_en = busWData[0]; m_ie = busWData[2]; m_os = busWData[3];
      end else if (wrap && m_os) begin
        m_en = 0;
      end
      if (wr && o == O_PSC) m_psc = lane_merge(m_psc, busWData, Byte_Enable);
      if (wr && o == O_ARR) m_arr = lane_merge(m_arr, busWData, Byte_Enable);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("model_rdata", busRData, m_read());
    chk("model_irq", {31'd0, irq}, {31'd0, m_uif & m_ie});
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    busSel = 0; busWe = 0; busAddr = '0; busWData = '0; Byte_Enable = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d, input logic [3:0] be = 4'hF);
    busSel = 1; busWe = 1; busAddr = {27'd0, o, 2'b00}; busWData = d; Byte_Enable = be;
    step(1);
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [2:0] o, input logic [31:0] exp);
    busSel = 1; busWe = 0; busAddr = {27'd0, o, 2'b00}; Byte_Enable = 4'h0;
    #1;
    chk(name, busRData, exp);
  endtask

  initial begin
    idle();
    reset = 0;
    step(3);
    reset = 1;
    step(1);

    // reset state
    rd_chk("rst_ctrl", O_CTRL, 32'h0);
    rd_chk("rst_psc", O_PSC, 32'h0);
    rd_chk("rst_cnt", O_CNT, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    step(1);

    // periodic counting: PSC=1, ARR=3, CTRL=EN|IE at edge 0
    wr(O_PSC, 32'd1);
    wr(O_ARR, 32'd3);
    wr(O_CTRL, 32'h5);
    for (int e = 1; e <= 16; e++) begin
      step(1);
      if (e == 2 || e == 4 || e == 6) rd_chk("per_cnt", O_CNT, e / 2);
      if (e == 7) rd_chk("per_stat_pre", O_STAT, 32'h0);
      if (e == 8 || e == 16) begin
        rd_chk("per_wrap_cnt", O_CNT, 32'h0);
        rd_chk("per_wrap_uif", O_STAT, 32'h1);
        chk("per_wrap_irq", {31'd0, irq}, 32'h1);
      end
      if (e == 10) rd_chk("per_cnt_again", O_CNT, 32'h1);
    end
    wr(O_CTRL, 32'h2);
    wr(O_STAT, 32'h1);
    rd_chk("stat_cleared", O_STAT, 32'h0);
    chk("irq_cleared", {31'd0, irq}, 32'h0);

    // byte enables
    wr(O_PSC, 32'h0);
    wr(O_PSC, 32'hAABBCCDD, 4'b0101);
    rd_chk("psc_be", O_PSC, 32'h00BB00DD);

    // one-shot: PSC=0, ARR=2, CTRL=EN|ONESHOT
    wr(O_PSC, 32'h0);
    wr(O_ARR, 32'd2);
    wr(O_CTRL, 32'h9);
    step(2);
    rd_chk("os_cnt2", O_CNT, 32'd2);
    rd_chk("os_stat_pre", O_STAT, 32'h0);
    step(1);
    rd_chk("os_uif", O_STAT, 32'h1);
    rd_chk("os_en_off", O_CTRL, 32'h8);
    rd_chk("os_cnt0", O_CNT, 32'h0);
    step(4);
    rd_chk("os_cnt_hold", O_CNT, 32'h0);
    wr(O_STAT, 32'h1);
    wr(O_CTRL, 32'h2);

    // W1C racing a hardware set: PSC=0, ARR=1, wraps at edges 2 and 4
    wr(O_PSC, 32'h0);
    wr(O_ARR, 32'd1);
    wr(O_CTRL, 32'h5);
    step(3);
    wr(O_STAT, 32'h1);
    rd_chk("w1c_race", O_STAT, 32'h1);
    wr(O_STAT, 32'h1);
    rd_chk("w1c_after", O_STAT, 32'h0);
    chk("w1c_irq", {31'd0, irq}, 32'h0);
    wr(O_CTRL, 32'h2);
    wr(O_STAT, 32'h1);

    // ARR lowered below CNT
    wr(O_CNT, 32'd9);
    wr(O_ARR, 32'd5);
    wr(O_PSC, 32'd0);
    wr(O_CTRL, 32'h1);
    rd_chk("arr_lo_pre", O_CNT, 32'd9);
    step(1);
    rd_chk("arr_lo_cnt", O_CNT, 32'h0);
    rd_chk("arr_lo_uif", O_STAT, 32'h1);
    wr(O_CTRL, 32'h2);
    wr(O_STAT, 32'h1);

    // unmapped offset
    wr(3'd7, 32'hFFFFFFFF);
    rd_chk("unmapped", 3'd7, 32'h0);

    // write without select
    busSel = 0; busWe = 1; busAddr = {27'd0, O_ARR, 2'b00};
    busWData = 32'h77; Byte_Enable = 4'hF;
    #1;
    chk("nosel_rd", busRData, 32'h0);
    step(1);
    idle();
    rd_chk("nosel_arr", O_ARR, 32'd5);

    // reset in the middle of counting
    wr(O_PSC, 32'd2);
    wr(O_ARR, 32'd7);
    wr(O_CTRL, 32'h5);
    step(10);
    reset = 0;
    rd_chk("mid_rst_cnt", O_CNT, 32'h0);
    rd_chk("mid_rst_psc", O_PSC, 32'h0);
    chk("mid_rst_irq", {31'd0, irq}, 32'h0);
    step(1);
    reset = 1;
    step(5);
    rd_chk("post_rst_cnt", O_CNT, 32'h0);
    rd_chk("post_rst_ctrl", O_CTRL, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  o;
      logic [31:0] d;
      o = 3'($urandom_range(0, 7));
      case (o)
        O_CTRL: begin
          d = 32'($urandom_range(0, 15));
          if ($urandom_range(0, 7) != 0) d[1] = 1'b0;
        end
        O_PSC:  d = 32'($urandom_range(0, 3));
        O_ARR:  d = 32'($urandom_range(0, 9));
        O_CNT:  d = 32'($urandom_range(0, 12));
        default: d = $urandom;
      endcase
      busSel      = ($urandom_range(0, 3) != 0);
      busWe       = ($urandom_range(0, 2) == 0);
      busAddr     = {27'($urandom), o, 2'($urandom)};
      busWData    = d;
      Byte_Enable = 4'($urandom);
      if ($urandom_range(0, 999) == 0) reset = 0;
      step(1);
      reset = 1;
    end
    idle();
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
